// File: rtl/rom_scan_controller.sv
// Raster-order address sequencer for the input image ROM, realigning the
// registered ROM data with its coordinates into a backpressured pixel stream.
module rom_scan_controller #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iStart,
  input  logic              iReady,
  input  logic [7:0]        iRomData,
  output logic [ADDR_W-1:0] oCol,
  output logic [ADDR_W-1:0] oRow,
  output logic              oValid,
  output logic [7:0]        oPixel,
  output logic [ADDR_W-1:0] oPixelCol,
  output logic [ADDR_W-1:0] oPixelRow,
  output logic              oLineEnd,
  output logic              oFrameEnd,
  output logic              oBusy,
  output logic              oDone
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int OUT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_col;
  logic [ADDR_W-1:0]  r_row;
  logic [OUT_W-1:0]   r_outstanding;
  logic               r_busy;
  logic               r_done;

  logic [READ_LATENCY-1:0] r_tagValid;
  logic [ADDR_W-1:0]       r_tagCol [READ_LATENCY];
  logic [ADDR_W-1:0]       r_tagRow [READ_LATENCY];

  logic [7:0]         r_memPix [DEPTH];
  logic [ADDR_W-1:0]  r_memCol [DEPTH];
  logic [ADDR_W-1:0]  r_memRow [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [OUT_W-1:0]   r_count;

  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic               w_lastAddr;
  logic [OUT_W-1:0]   w_outAfterPop;
  logic [OUT_W-1:0]   w_outNext;

  // A slot is only claimed once the FIFO is guaranteed room for the returning byte.
  assign w_pop         = (r_count != '0) && iReady;
  assign w_outAfterPop = r_outstanding - OUT_W'(w_pop);
  assign w_issue       = (r_state == SCAN) && (w_outAfterPop < OUT_W'(DEPTH));
  assign w_outNext     = w_outAfterPop + OUT_W'(w_issue);
  assign w_push        = r_tagValid[READ_LATENCY-1];
  assign w_lastAddr    = (r_col == ADDR_W'(WIDTH - 1)) && (r_row == ADDR_W'(HEIGHT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_outstanding <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_outstanding <= w_outNext;
      r_done        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_state <= SCAN;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (w_issue) begin
            if (w_lastAddr) begin
              r_state <= DRAIN;
            end else if (r_col == ADDR_W'(WIDTH - 1)) begin
              r_col <= '0;
              r_row <= r_row + ADDR_W'(1);
            end else begin
              r_col <= r_col + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_outNext == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Coordinates travel alongside the ROM access so data and tag meet at the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tagValid[i] <= 1'b0;
        r_tagCol[i]   <= '0;
        r_tagRow[i]   <= '0;
      end
    end else begin
      r_tagValid[0] <= w_issue;
      r_tagCol[0]   <= r_col;
      r_tagRow[0]   <= r_row;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagCol[i]   <= r_tagCol[i-1];
        r_tagRow[i]   <= r_tagRow[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_memPix[i] <= '0;
        r_memCol[i] <= '0;
        r_memRow[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_memPix[r_wrPtr] <= iRomData;
        r_memCol[r_wrPtr] <= r_tagCol[READ_LATENCY-1];
        r_memRow[r_wrPtr] <= r_tagRow[READ_LATENCY-1];
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + OUT_W'(w_push) - OUT_W'(w_pop);
    end
  end

  assign oCol      = r_col;
  assign oRow      = r_row;
  assign oValid    = (r_count != '0);
  assign oPixel    = r_memPix[r_rdPtr];
  assign oPixelCol = r_memCol[r_rdPtr];
  assign oPixelRow = r_memRow[r_rdPtr];
  assign oLineEnd  = oValid && (oPixelCol == ADDR_W'(WIDTH - 1));
  assign oFrameEnd = oLineEnd && (oPixelRow == ADDR_W'(HEIGHT - 1));
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule

// File: tb/tb_rom_scan_controller.sv
// Scoreboard bench: raster-order reference frames are queued at start,
// negedge monitors pop and compare every accepted pixel of two DUT instances.
module tb_rom_scan_controller;

  localparam int W     = 128;
  localparam int H     = 128;
  localparam int AW    = 8;
  localparam int RL    = 1;
  localparam int RL3   = 3;
  localparam int DEPTH = RL + 2;
  localparam int NPIX  = W * H;

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] col;
    logic [7:0] row;
    logic       lineEnd;
    logic       frameEnd;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic          iStart, iReady;
  logic [7:0]    iRomData;
  logic [AW-1:0] oCol, oRow, oPixelCol, oPixelRow;
  logic          oValid, oLineEnd, oFrameEnd, oBusy, oDone;
  logic [7:0]    oPixel;

  logic          iStart3, iReady3;
  logic [7:0]    iRomData3;
  logic [AW-1:0] oCol3, oRow3, oPixelCol3, oPixelRow3;
  logic          oValid3, oLineEnd3, oFrameEnd3, oBusy3, oDone3;
  logic [7:0]    oPixel3;

  pix_t q1[$];
  pix_t q3[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startCyc1, startCyc3;
  int firstRel1, lastRel1, doneRel1, pixCount1, lineEnds1, doneCount1;
  int firstRel3, lastRel3, pixCount3, doneCount3;
  logic [7:0] patOff1, patOff3;
  logic [7:0] rom1, rom3a, rom3b, rom3c;
  logic        holdPrev;
  logic [31:0] prevSnap;

  rom_scan_controller #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LATENCY(RL)) dut1 (
    .clock(clock), .reset(reset), .iStart(iStart), .iReady(iReady), .iRomData(iRomData),
    .oCol(oCol), .oRow(oRow), .oValid(oValid), .oPixel(oPixel), .oPixelCol(oPixelCol),
    .oPixelRow(oPixelRow), .oLineEnd(oLineEnd), .oFrameEnd(oFrameEnd), .oBusy(oBusy), .oDone(oDone)
  );

  rom_scan_controller #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .READ_LATENCY(RL3)) dut3 (
    .clock(clock), .reset(reset), .iStart(iStart3), .iReady(iReady3), .iRomData(iRomData3),
    .oCol(oCol3), .oRow(oRow3), .oValid(oValid3), .oPixel(oPixel3), .oPixelCol(oPixelCol3),
    .oPixelRow(oPixelRow3), .oLineEnd(oLineEnd3), .oFrameEnd(oFrameEnd3), .oBusy(oBusy3), .oDone(oDone3)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int row, input int col, input logic [7:0] off);
    return 8'(row * 3 + col + int'(off));
  endfunction

  // ROM models: one and three registered stages between address and data.
  always @(posedge clock) begin
    rom1  <= pat(int'(oRow), int'(oCol), patOff1);
    rom3a <= pat(int'(oRow3), int'(oCol3), patOff3);
    rom3b <= rom3a;
    rom3c <= rom3b;
  end
  assign iRomData  = rom1;
  assign iRomData3 = rom3c;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic queueFrame(input int lane, input logic [7:0] off);
    pix_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.pix      = pat(r, c, off);
        e.col      = 8'(c);
        e.row      = 8'(r);
        e.lineEnd  = (c == W - 1);
        e.frameEnd = (c == W - 1) && (r == H - 1);
        if (lane == 1) q1.push_back(e);
        else q3.push_back(e);
      end
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_addr"}, {16'h0, oCol, oRow}, 32'h0);
    checkOutput({name, "_coord"}, {16'h0, oPixelCol, oPixelRow}, 32'h0);
    checkOutput({name, "_flags"}, {19'h0, oValid, oPixel, oLineEnd, oFrameEnd, oBusy, oDone}, 32'h0);
  endtask

  // Lane-1 monitor: scoreboard pop, hold stability, done/busy and occupancy bound.
  always @(negedge clock) begin
    pix_t e;
    if (reset) begin
      holdPrev = 1'b0;
    end else begin
      if (holdPrev)
        checkOutput("holdStable", {7'h0, oValid, oPixel, oPixelCol, oPixelRow}, prevSnap);
      if (oValid) checkOutput("busyWhileValid", {31'h0, oBusy}, 32'h1);
      checkOutput("fifoNoOverflow", {31'h0, (dut1.r_count <= DEPTH)}, 32'h1);
      if (oValid && iReady) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPixel: got (%0d,%0d) required none", oPixelCol, oPixelRow);
        end else begin
          e = q1.pop_front();
          checkOutput("pixel", {6'h0, oPixel, oPixelCol, oPixelRow, oLineEnd, oFrameEnd}, {6'h0, e});
          if (firstRel1 < 0) firstRel1 = cyc - startCyc1;
          if (oFrameEnd) lastRel1 = cyc - startCyc1;
          if (oLineEnd) lineEnds1++;
          pixCount1++;
        end
      end
      holdPrev = oValid && !iReady;
      prevSnap = {7'h0, oValid, oPixel, oPixelCol, oPixelRow};
      if (oDone) begin
        doneCount1++;
        doneRel1 = cyc - startCyc1;
        checkOutput("doneNotBusy", {31'h0, oBusy}, 32'h0);
        checkOutput("doneQueueEmpty", q1.size(), 32'h0);
      end
    end
  end

  always @(negedge clock) begin
    pix_t e;
    if (!reset) begin
      if (oValid3 && iReady3) begin
        if (q3.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPixel3: got (%0d,%0d) required none", oPixelCol3, oPixelRow3);
        end else begin
          e = q3.pop_front();
          checkOutput("pixel3", {6'h0, oPixel3, oPixelCol3, oPixelRow3, oLineEnd3, oFrameEnd3}, {6'h0, e});
          if (firstRel3 < 0) firstRel3 = cyc - startCyc3;
          if (oFrameEnd3) lastRel3 = cyc - startCyc3;
          pixCount3++;
        end
      end
      if (oDone3) doneCount3++;
    end
  end

  task automatic applyStimulus(input bit lane3);
    firstRel1 = -1; lastRel1 = -1; pixCount1 = 0; lineEnds1 = 0;
    startCyc1 = cyc;
    iStart = 1'b1;
    if (lane3) begin
      firstRel3 = -1; lastRel3 = -1; pixCount3 = 0;
      startCyc3 = cyc;
      iStart3 = 1'b1;
    end
    @(posedge clock); #1;
    iStart  = 1'b0;
    iStart3 = 1'b0;
  endtask

  // mode 0: ready always; mode 1: one 5-cycle stall at (5,0) plus stray starts; mode 2: random ready.
  task automatic runUntilDone(input int mode, input int budget);
    int d0 = doneCount1;
    int n = 0;
    int stallLeft = 0;
    bit stalled = 0;
    while (doneCount1 == d0 && n < budget) begin
      @(posedge clock); #1;
      n++;
      if (mode == 0) begin
        iReady = 1'b1;
      end else if (mode == 1) begin
        iStart = oBusy && ($urandom_range(0, 99) < 3);
        if (stallLeft > 0) begin
          stallLeft--;
          if (stallLeft == 1) begin
            checkOutput("stallAddrCol", {24'h0, oCol}, 32'(5 + DEPTH));
            checkOutput("stallAddrRow", {24'h0, oRow}, 32'h0);
          end
          if (stallLeft == 0) iReady = 1'b1;
        end else if (!stalled && oValid && oPixelCol == 5 && oPixelRow == 0) begin
          iReady = 1'b0;
          stallLeft = 5;
          stalled = 1;
        end
      end else begin
        iReady = 1'($urandom_range(0, 1));
      end
    end
    iStart = 1'b0;
    iReady = 1'b1;
    if (doneCount1 == d0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no oDone within %0d cycles", budget);
    end
    repeat (6) @(posedge clock);
    #1;
    checkOutput("doneOnce", doneCount1 - d0, 32'h1);
    checkOutput("pixelCount", pixCount1, NPIX);
    checkOutput("lineEndCount", lineEnds1, H);
    if (mode == 1) checkOutput("stallHappened", {31'h0, stalled}, 32'h1);
  endtask

  initial begin
    iStart = 0; iReady = 1; iStart3 = 0; iReady3 = 1;
    patOff1 = 8'h0; patOff3 = 8'h0;
    doneCount1 = 0; doneCount3 = 0;
    firstRel1 = -1; firstRel3 = -1;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("resetState");
    reset = 1'b0;

    // Full frame on both latencies with continuous ready.
    $display("[TB] full frame, READ_LATENCY 1 and 3");
    queueFrame(1, patOff1);
    queueFrame(3, patOff3);
    applyStimulus(1'b1);
    runUntilDone(0, NPIX + 100);
    checkOutput("firstValidCycle", firstRel1, 32'(2 + RL));
    checkOutput("lastPixelCycle", lastRel1, 32'(NPIX + 1 + RL));
    checkOutput("doneCycle", doneRel1, 32'(NPIX + 2 + RL));
    checkOutput("firstValidCycle3", firstRel3, 32'(2 + RL3));
    checkOutput("lastPixelCycle3", lastRel3, 32'(NPIX + 1 + RL3));
    checkOutput("pixelCount3", pixCount3, NPIX);
    checkOutput("doneOnce3", doneCount3, 32'h1);

    // Backpressure at (5,0) with iStart pulses during SCAN/DRAIN.
    $display("[TB] backpressure and ignored starts");
    patOff1 = 8'($urandom);
    queueFrame(1, patOff1);
    applyStimulus(1'b0);
    runUntilDone(1, NPIX + 200);

    // Same frame restarted right after oDone, random ready.
    $display("[TB] second frame, random ready");
    queueFrame(1, patOff1);
    applyStimulus(1'b0);
    runUntilDone(2, 4 * NPIX);

    // Abort mid-frame at (40,17).
    $display("[TB] reset mid-frame");
    patOff1 = 8'($urandom);
    queueFrame(1, patOff1);
    applyStimulus(1'b0);
    for (int n = 0; n < 4000; n++) begin
      if (oValid && oPixelCol == 40 && oPixelRow == 17) break;
      @(posedge clock); #1;
    end
    checkOutput("reachedAbortPoint", {16'h0, oPixelCol, oPixelRow}, {16'h0, 8'd40, 8'd17});
    reset = 1'b1;
    iReady = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    iReady = 1'b1;
    q1.delete();
    checkAllZero("abortState");
    repeat (8) begin
      @(posedge clock); #1;
      checkOutput("quietAfterAbort", {30'h0, oValid, oBusy}, 32'h0);
    end

    // Restart from (0,0) after the abort; checked over the first rows.
    queueFrame(1, patOff1);
    applyStimulus(1'b0);
    for (int n = 0; n < 600 && pixCount1 < 300; n++) begin
      @(posedge clock); #1;
    end
    checkOutput("restartFirstValid", firstRel1, 32'(2 + RL));
    checkOutput("restartPixels", {31'h0, (pixCount1 >= 300)}, 32'h1);
    reset = 1'b1;
    @(posedge clock); #1;
    q1.delete();
    @(posedge clock); #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_scan_controller.md
Name: rom_scan_controller

Overview:
Sequences the 128x128 input image ROM reader in raster order (row-major, col fastest) and drives its iCol/iRow address inputs. Compensates for the ROM's registered read latency and re-times each returned byte into a valid/ready pixel stream tagged with its coordinates. A small skid FIFO absorbs downstream backpressure. Sits between input_rom_reader and the adaptive-thresholding datapath, started once per frame by top-level control.

Parameters:
WIDTH, 128, pixels per row
HEIGHT, 128, rows per frame
ADDR_W, 8, width of column/row coordinates (must hold WIDTH-1 and HEIGHT-1)
READ_LATENCY, 1, cycles from address driven to iRomData valid (legal 1..3)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
iStart  in  1  start-frame pulse; honoured only in IDLE
iReady  in  1  downstream accepts pixel this cycle
iRomData  in  8  ROM reader oData
oCol  out  ADDR_W  column address to ROM reader (registered)
oRow  out  ADDR_W  row address to ROM reader (registered)
oValid  out  1  oPixel/oPixelCol/oPixelRow valid
oPixel  out  8  pixel value
oPixelCol  out  ADDR_W  column of oPixel
oPixelRow  out  ADDR_W  row of oPixel
oLineEnd  out  1  oValid and oPixelCol==WIDTH-1
oFrameEnd  out  1  oValid and last pixel of frame
oBusy  out  1  high in SCAN or DRAIN
oDone  out  1  one-cycle pulse after final pixel accepted

Behaviour:
- Reset: state=IDLE; oCol=oRow=0; oValid=0; oPixel/oPixelCol/oPixelRow=0; oLineEnd=oFrameEnd=oBusy=oDone=0; FIFO and in-flight tag pipeline flushed; outstanding count=0. Reset mid-frame aborts immediately with no further pixels.
- FSM: IDLE -(iStart)-> SCAN -(last address issued)-> DRAIN -(outstanding==0)-> DONE -(always)-> IDLE. iStart outside IDLE is ignored.
- Issue: in SCAN, an address issues in a cycle when (outstanding - pop) < DEPTH, where DEPTH = READ_LATENCY+2 and pop = oValid & iReady. Issued address is the value on oCol/oRow that cycle; the next address is loaded at the clock edge ending the cycle. Col increments, wraps to 0 at WIDTH-1 and increments row. After (WIDTH-1, HEIGHT-1) issues, go to DRAIN; oCol/oRow hold the last address.
- Entering SCAN sets oCol=oRow=0. Address (0,0) is issued in the first SCAN cycle.
- Tag pipeline: {col,row,issue-valid} delayed READ_LATENCY cycles. In cycle t+READ_LATENCY, iRomData belongs to the address issued in cycle t. It is pushed into the FIFO with its tag at the end of that cycle.
- FIFO: DEPTH entries; the head drives the outputs. Push and pop in the same cycle are allowed. Overflow cannot occur by construction; the bench asserts this.
- outstanding = issued - popped (in-flight + buffered), width ceil(log2(DEPTH+1)). It increments on issue and decrements on pop; both in the same cycle leaves it unchanged.
- Output: oValid=FIFO non-empty. While oValid & !iReady, all output fields hold stable.
- Latency with iReady=1: iStart high in cycle 0 gives first oValid in cycle 2+READ_LATENCY. Throughput is 1 pixel/cycle with no bubbles.
- oDone: single cycle in DONE, i.e. the cycle after the pop of the final pixel. oBusy is low in that cycle.
- No pixel is dropped, duplicated or reordered under any iReady pattern.

Test Plan:
- Full frame, iReady=1, READ_LATENCY=1, ROM holds pattern row*3+col (mod 256): iStart cycle 0 -> first oValid cycle 3 at (0,0); last pixel (127,127) at cycle 16386 with oFrameEnd=1; oDone cycle 16387 only; 16384 pixels, all values match; 128 oLineEnd pulses.
- Backpressure: iReady low 5 cycles while pixel (5,0) is at the head -> outputs stay (5,0) with the same data; oCol/oRow stall once outstanding=3; after release the stream resumes at (6,0) with no gaps or duplicates.
- Random iReady (50%) over a full frame -> the scoreboard sees exactly 16384 in-order pixels; the FIFO never overflows; oDone fires once.
- iStart pulsed during SCAN and DRAIN -> ignored; the frame completes normally; an iStart after oDone starts a second identical frame.
- reset asserted mid-frame at pixel (40,17) -> next cycle all outputs are zero and state is IDLE; a new iStart restarts at (0,0).
- READ_LATENCY=3 full frame, iReady=1 -> first oValid cycle 5; throughput 1 pixel/cycle; data alignment is correct.
